// File: rtl/fifo12_rd_stream_pkg.sv
// Shared constants and the skid-buffer entry type for the FIFO read-side drain engine.
package fifo12_rd_stream_pkg;

  localparam int FIFO_DW      = 12;
  localparam int DEF_LINE_LEN = 64;
  localparam int FIFO_RD_LAT  = 1;

  typedef struct packed {
    logic [FIFO_DW-1:0] data;
    logic               first;
    logic               last;
  } entry_t;

endpackage

// File: rtl/fifo12_rd_stream_if.sv
// Framed valid/ready word stream toward the LED scan logic.
interface fifo12_rd_stream_if #(
  parameter int DW = fifo12_rd_stream_pkg::FIFO_DW
);
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_first;
  logic          m_last;

  modport master (output m_data, output m_valid, output m_first, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_first, input m_last, output m_ready);
endinterface

// File: rtl/fifo12_skid2.sv
// Two-entry in-order buffer of {data, first, last}; head is entry 0, push and pop may coincide.
module fifo12_skid2
  import fifo12_rd_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  entry_t     din,
  output entry_t     head,
  output logic [1:0] occ
);

  entry_t e0;
  entry_t e1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) e0 <= din;
          else             e1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          // The popped head is replaced by the older survivor when one exists.
          if (occ == 2'd2) begin
            e0 <= e1;
            e1 <= din;
          end else begin
            e0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = e0;

endmodule

// File: rtl/fifo12_rd_stream.sv
// Drains the async FIFO read port into a line-framed valid/ready stream; re at N gives m_valid at N+2.
module fifo12_rd_stream
  import fifo12_rd_stream_pkg::*;
#(
  parameter int DW       = FIFO_DW,
  parameter int LINE_LEN = DEF_LINE_LEN,
  parameter int CW       = 12
) (
  input  logic                 clkr,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic                 fifo_aempty,
  input  logic [DW-1:0]        fifo_do,
  output logic                 fifo_re,
  fifo12_rd_stream_if.master   m,
  output logic [15:0]          line_cnt,
  output logic                 starve
);

  logic          inflight;
  logic          pop;
  logic [1:0]    occ;
  logic [2:0]    committed;
  logic [CW-1:0] idx;
  entry_t        din;
  entry_t        head;
  logic          valid;
  logic          unused_aempty;

  assign unused_aempty = fifo_aempty;

  assign valid = (occ != 2'd0);
  assign pop   = valid & m.m_ready;

  // Slots still spoken for after this cycle: occupancy net of the leaving word plus the word
  // on the FIFO bus. Counting the pop is what lets a ready consumer sustain one word per cycle.
  assign committed = {1'b0, occ} - {2'b00, pop} + {2'b00, inflight};
  assign fifo_re   = rst_n & en & ~fifo_empty & (committed < 3'd2);

  assign din = '{data:  fifo_do,
                 first: (idx == '0),
                 last:  (idx == CW'(LINE_LEN - 1))};

  always_ff @(posedge clkr) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      idx      <= '0;
      line_cnt <= 16'd0;
      starve   <= 1'b0;
    end else begin
      inflight <= fifo_re;
      if (inflight) idx <= (idx == CW'(LINE_LEN - 1)) ? '0 : idx + 1'b1;
      if (pop && head.last) line_cnt <= line_cnt + 16'd1;
      starve <= en & fifo_empty & (occ == 2'd0);
    end
  end

  fifo12_skid2 u_skid (
    .clk   (clkr),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .occ   (occ)
  );

  assign m.m_valid = valid;
  assign m.m_data  = head.data;
  assign m.m_first = valid & head.first;
  assign m.m_last  = valid & head.last;

endmodule

// File: tb/tb_fifo12_rd_stream.sv
// Bench for fifo12_rd_stream: queue-based FIFO model plus a positional reference of the expected stream.
module tb_fifo12_rd_stream;
  import fifo12_rd_stream_pkg::*;

  localparam int LL = 64;

  logic        clkr = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_aempty = 1'b1;
  logic [11:0] fifo_do = 12'd0;
  logic        fifo_re;
  logic [15:0] line_cnt;
  logic        starve;

  fifo12_rd_stream_if sif ();

  fifo12_rd_stream #(.LINE_LEN(LL)) dut (
    .clkr        (clkr),
    .rst_n       (rst_n),
    .en          (en),
    .fifo_empty  (fifo_empty),
    .fifo_aempty (fifo_aempty),
    .fifo_do     (fifo_do),
    .fifo_re     (fifo_re),
    .m           (sif.master),
    .line_cnt    (line_cnt),
    .starve      (starve)
  );

  always #5 clkr = ~clkr;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: words pushed by the stimulus, read data valid one cycle after re.
  logic [11:0] fq[$];
  logic [11:0] ref_q[$];
  int  nreads = 0;
  bit  flush = 0;
  bit  tog = 0;
  bit  force_e = 0;
  int  tcnt = 0;

  always @(posedge clkr) begin
    if (flush) begin
      fq.delete();
      nreads = 0;
      fifo_do <= 12'($urandom);
    end else if (fifo_re && fq.size() > 0) begin
      fifo_do <= fq.pop_front();
      nreads++;
    end else begin
      fifo_do <= 12'($urandom);
    end
    if (tog) begin
      tcnt++;
      if (tcnt % 3 == 0) force_e = !force_e;
    end else begin
      force_e = 0;
    end
    fifo_empty  <= (fq.size() == 0) || force_e;
    fifo_aempty <= (fq.size() < 4);
  end

  task automatic push_word(input logic [11:0] w);
    fq.push_back(w);
    ref_q.push_back(w);
  endtask

  // Stream monitor: the n-th word since reset must be ref_q[n], framed by n mod LL.
  int          dcount = 0;
  int          exp_lines = 0;
  int          cyc = 0;
  bit          have_prev = 0;
  bit          prev_stall = 0;
  logic [13:0] prev_word;
  logic        exp_starve = 0;
  int          first_re_cyc = -1;
  int          first_vld_cyc = -1;
  int          first_pop_cyc = 0;
  int          last_pop_cyc = 0;
  int          starve_seen = 0;

  always @(negedge clkr) begin
    cyc++;
    if (first_re_cyc < 0 && fifo_re === 1'b1) first_re_cyc = cyc;
    if (first_vld_cyc < 0 && sif.m_valid === 1'b1) first_vld_cyc = cyc;
    check("re_while_empty", {31'd0, fifo_re & fifo_empty}, 32'd0);
    if (have_prev) check("starve", {31'd0, starve}, {31'd0, exp_starve});
    if (starve === 1'b1) starve_seen++;
    exp_starve = rst_n & en & fifo_empty & ~sif.m_valid;
    have_prev = 1;
    if (!rst_n) begin
      dcount = 0;
      exp_lines = 0;
      prev_stall = 0;
    end else begin
      check("occ_le2", {31'd0, dut.u_skid.occ <= 2'd2}, 32'd1);
      if (prev_stall) begin
        check("stall_valid", {31'd0, sif.m_valid}, 32'd1);
        check("stall_hold", {18'd0, sif.m_data, sif.m_first, sif.m_last}, {18'd0, prev_word});
      end
      check("line_cnt", {16'd0, line_cnt}, exp_lines);
      if (sif.m_valid && sif.m_ready) begin
        if (dcount < ref_q.size()) begin
          check("data", {20'd0, sif.m_data}, {20'd0, ref_q[dcount]});
          check("first", {31'd0, sif.m_first}, {31'd0, dcount % LL == 0});
          check("last", {31'd0, sif.m_last}, {31'd0, dcount % LL == LL - 1});
          if (dcount % LL == LL - 1) exp_lines = (exp_lines + 1) & 32'hFFFF;
        end else begin
          check("extra_word", dcount, ref_q.size());
        end
        if (dcount == 0) first_pop_cyc = cyc;
        if (dcount == 127) last_pop_cyc = cyc;
        dcount++;
      end
      prev_stall = sif.m_valid && !sif.m_ready;
      prev_word  = {sif.m_data, sif.m_first, sif.m_last};
    end
  end

  int target;
  int reads_at_drop;

  initial begin
    sif.m_ready = 1'b1;
    rst_n = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) fq.push_back(12'(12'h100 + i));

    // Reset held with a non-empty FIFO: nothing may be read or presented.
    @(posedge clkr); #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clkr); #1;
      check("rst_fifo_re", {31'd0, fifo_re}, 32'd0);
      check("rst_m_valid", {31'd0, sif.m_valid}, 32'd0);
      check("rst_line_cnt", {16'd0, line_cnt}, 32'd0);
      check("rst_starve", {31'd0, starve}, 32'd0);
    end
    en = 1'b0;
    flush = 1;
    @(posedge clkr); #1;
    flush = 0;

    // Two full lines at full rate.
    for (int w = 1; w <= 128; w++) push_word(12'(w));
    first_re_cyc = -1;
    first_vld_cyc = -1;
    rst_n = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 400 && dcount < 128; k++) begin @(posedge clkr); #1; end
    check("stream_done", dcount, 128);
    check("stream_rate", last_pop_cyc - first_pop_cyc, 127);
    check("latency", first_vld_cyc - first_re_cyc, 2);
    @(posedge clkr); #1;
    check("stream_lines", {16'd0, line_cnt}, 32'd2);

    // Random back-pressure, ~30% ready.
    for (int i = 0; i < 500; i++) push_word(12'($urandom));
    target = ref_q.size();
    for (int k = 0; k < 8000 && dcount < target; k++) begin
      @(posedge clkr); #1;
      sif.m_ready = ($urandom_range(0, 9) < 3);
    end
    sif.m_ready = 1'b1;
    check("bp_done", dcount, target);

    // FIFO empty flag toggling every 3 cycles.
    starve_seen = 0;
    tog = 1;
    for (int i = 0; i < 60; i++) push_word(12'($urandom));
    target = ref_q.size();
    for (int k = 0; k < 1000 && dcount < target; k++) begin @(posedge clkr); #1; end
    tog = 0;
    check("empty_toggle_done", dcount, target);
    check("starve_seen", {31'd0, starve_seen > 0}, 32'd1);

    // en dropped the cycle after a read: the in-flight word still arrives, reads stop.
    for (int i = 0; i < 20; i++) push_word(12'($urandom));
    target = ref_q.size();
    for (int k = 0; k < 50 && fifo_re !== 1'b1; k++) begin @(posedge clkr); #1; end
    check("endrop_re_seen", {31'd0, fifo_re}, 32'd1);
    @(posedge clkr); #1;
    en = 1'b0;
    reads_at_drop = nreads;
    for (int k = 0; k < 10; k++) begin
      @(posedge clkr); #1;
      check("endrop_no_re", {31'd0, fifo_re}, 32'd0);
    end
    check("endrop_reads", nreads, reads_at_drop);
    check("endrop_delivered", dcount, nreads);
    check("endrop_left", {31'd0, fq.size() > 0}, 32'd1);
    en = 1'b1;
    for (int k = 0; k < 200 && dcount < target; k++) begin @(posedge clkr); #1; end
    check("endrop_drain", dcount, target);

    // Reset after word 10 of a line.
    for (int i = 0; i < 40; i++) push_word(12'($urandom));
    target = (dcount / LL) * LL + 11;
    for (int k = 0; k < 200 && dcount < target; k++) begin @(posedge clkr); #1; end
    check("midline_pos", dcount, target);
    rst_n = 1'b0;
    en = 1'b0;
    ref_q.delete();
    flush = 1;
    @(posedge clkr); #1;
    flush = 0;
    @(posedge clkr); #1;
    for (int i = 0; i < 20; i++) push_word(12'($urandom));
    rst_n = 1'b1;
    en = 1'b1;
    @(posedge clkr); #1;
    check("midline_lines", {16'd0, line_cnt}, 32'd0);
    for (int k = 0; k < 200 && dcount < 20; k++) begin @(posedge clkr); #1; end
    check("midline_done", dcount, 20);
    check("midline_lines_end", {16'd0, line_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
